// File: rtl/duty_level_selector.sv
// duty_level_selector: turns raw up/down push-buttons into a saturating
// 4-bit duty level for pwm_counter. Each button is synchronized, debounced
// and edge-detected; accepted presses step the level by one within
// 0..MAX_LEVEL.
// Optional feature: define DUTY_LEVEL_SELECTOR_AUTO_REPEAT_EN to add
// hold-to-repeat stepping (REPEAT_DELAY, then every REPEAT_PERIOD cycles).
// Handshake note: there is no valid/ready traffic here; each press pulse is a
// single-cycle event that is consumed by the level register in that cycle.
// Bit 0 of every per-button vector is the up button, bit 1 is down.
module duty_level_selector #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MAX_LEVEL       = 10,
    parameter int RESET_LEVEL     = 0,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] duty_multiplier,
    output logic       level_changed,
    output logic       at_min,
    output logic       at_max
);

    localparam logic [3:0]  MAX_L   = 4'(MAX_LEVEL);
    localparam logic [3:0]  RST_L   = 4'(RESET_LEVEL);
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES);

    logic [1:0]  sync1;
    logic [1:0]  sync2;
    logic [1:0]  stable;
    logic [1:0]  stable_q;
    logic [1:0]  press;
    logic [1:0]  step;
    logic [15:0] db_cnt [2];
    logic [3:0]  level;
    logic [3:0]  next_level;

    // Two-flop synchronizer for both raw buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= {btn_down, btn_up};
            sync2 <= sync1;
        end
    end

    // Debounce: accept a new state only after it persists past DEBOUNCE_CYCLES;
    // any return to the stable value throws away the partial count.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable    <= 2'b00;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 16'd1;
                end
            end
        end
    end

    // Rising-edge detect on the debounced state; releases produce nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q <= 2'b00;
            press    <= 2'b00;
        end else begin
            stable_q <= stable;
            press    <= stable & ~stable_q;
        end
    end

`ifdef DUTY_LEVEL_SELECTOR_AUTO_REPEAT_EN
    localparam logic [15:0] RPT_FIRST = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] RPT_NEXT  = 16'(REPEAT_PERIOD - 1);

    logic [15:0] rpt_cnt [2];
    logic [1:0]  rpt_first;
    logic [1:0]  rpt_pulse;

    // Auto-repeat: counts from the press pulse while held; the first synthetic
    // press waits REPEAT_DELAY, later ones REPEAT_PERIOD. Release clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_cnt[0] <= '0;
            rpt_cnt[1] <= '0;
            rpt_first  <= 2'b11;
            rpt_pulse  <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                rpt_pulse[i] <= 1'b0;
                if (!stable[i] || !stable_q[i]) begin
                    rpt_cnt[i]   <= '0;
                    rpt_first[i] <= 1'b1;
                end else if (rpt_cnt[i] == (rpt_first[i] ? RPT_FIRST : RPT_NEXT)) begin
                    rpt_cnt[i]   <= '0;
                    rpt_first[i] <= 1'b0;
                    rpt_pulse[i] <= 1'b1;
                end else begin
                    rpt_cnt[i] <= rpt_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign step = press | rpt_pulse;
`else
    assign step = press;
`endif

    // Saturating next level; simultaneous up and down cancel.
    always_comb begin
        next_level = level;
        if (step == 2'b01 && level != MAX_L) begin
            next_level = level + 4'd1;
        end else if (step == 2'b10 && level != 4'd0) begin
            next_level = level - 4'd1;
        end
    end

    // Level register and its change pulse, updated on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            level         <= RST_L;
            level_changed <= 1'b0;
        end else begin
            level         <= next_level;
            level_changed <= (next_level != level);
        end
    end

    assign duty_multiplier = level;
    assign at_min          = (level == 4'd0);
    assign at_max          = (level == MAX_L);

endmodule

// File: tb/tb_duty_level_selector.sv
// Bench for duty_level_selector with DEBOUNCE_CYCLES=4, MAX_LEVEL=10,
// RESET_LEVEL=0 in the default build (no auto-repeat).
module tb_duty_level_selector;

    localparam int DB  = 4;
    localparam int MAX = 10;
    localparam int RL  = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [3:0] duty_multiplier;
    logic       level_changed;
    logic       at_min;
    logic       at_max;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;

    duty_level_selector #(
        .DEBOUNCE_CYCLES(DB),
        .MAX_LEVEL(MAX),
        .RESET_LEVEL(RL),
        .REPEAT_DELAY(64),
        .REPEAT_PERIOD(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .duty_multiplier(duty_multiplier),
        .level_changed(level_changed),
        .at_min(at_min),
        .at_max(at_max)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model: button samples arrive two edges late, a state change is
    // accepted on its (DB+1)th consecutive differing sample, and an accepted
    // rise moves the level two edges later.
    logic [1:0] m_s1 = 2'b00;
    logic [1:0] m_s2 = 2'b00;
    logic [1:0] m_stable = 2'b00;
    logic [1:0] m_ev0 = 2'b00;
    logic [1:0] m_ev1 = 2'b00;
    int         m_run [2] = '{0, 0};
    int         m_level = RL;
    logic       m_changed = 1'b0;
    logic       model_valid = 1'b0;

    always @(posedge clk) begin
        logic [1:0] new_stable;
        logic [1:0] rise;
        logic [1:0] apply;
        int         old_level;
        if (rst) begin
            m_s1 = 2'b00; m_s2 = 2'b00; m_stable = 2'b00;
            m_ev0 = 2'b00; m_ev1 = 2'b00;
            m_run[0] = 0; m_run[1] = 0;
            m_level = RL; m_changed = 1'b0;
            model_valid = 1'b1;
        end else begin
            new_stable = m_stable;
            for (int i = 0; i < 2; i++) begin
                if (m_s2[i] != m_stable[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] > DB) begin
                        new_stable[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            rise  = new_stable & ~m_stable;
            apply = m_ev1;
            m_ev1 = m_ev0;
            m_ev0 = rise;
            old_level = m_level;
            if (apply == 2'b01) m_level = (m_level + 1 > MAX) ? MAX : m_level + 1;
            else if (apply == 2'b10) m_level = (m_level - 1 < 0) ? 0 : m_level - 1;
            m_changed = (m_level != old_level);
            m_stable = new_stable;
            m_s2 = m_s1;
            m_s1 = {btn_down, btn_up};
        end
    end

    // Scoreboard: compare every cycle against the model, away from the edge.
    always @(negedge clk) begin
        if (level_changed === 1'b1) pulse_cnt = pulse_cnt + 1;
        if (model_valid) begin
            n_checks = n_checks + 1;
            if (duty_multiplier !== 4'(m_level) || level_changed !== m_changed ||
                at_min !== (m_level == 0) || at_max !== (m_level == MAX)) begin
                n_fail = n_fail + 1;
                $display("FAIL model_cmp t=%0t: duty=%0d chg=%0b min=%0b max=%0b, expected duty=%0d chg=%0b min=%0b max=%0b",
                         $time, duty_multiplier, level_changed, at_min, at_max,
                         m_level, m_changed, (m_level == 0), (m_level == MAX));
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks = n_checks + 1;
        if (got != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic press_up();
        btn_up = 1'b1; cycles(10);
        btn_up = 1'b0; cycles(10);
    endtask

    task automatic press_down();
        btn_down = 1'b1; cycles(10);
        btn_down = 1'b0; cycles(10);
    endtask

    initial begin
        int p0;
        // Reset: 3 cycles, buttons low
        rst = 1'b1;
        cycles(3);
        check("reset_duty", duty_multiplier, 0);
        check("reset_at_min", at_min, 1);
        check("reset_at_max", at_max, 0);
        check("reset_changed", level_changed, 0);
        rst = 1'b0;
        cycles(2);

        // Single step: first sample at edge 0, level moves at edge 8
        p0 = pulse_cnt;
        btn_up = 1'b1;
        cycles(8);
        check("step_before_edge8", duty_multiplier, 0);
        cycles(1);
        check("step_at_edge8", duty_multiplier, 1);
        check("step_changed_pulse", level_changed, 1);
        cycles(11);
        btn_up = 1'b0;
        cycles(20);
        check("step_pulse_count", pulse_cnt - p0, 1);
        check("step_final", duty_multiplier, 1);

        // Back to 0 for the bounce test
        press_down();
        check("back_to_zero", duty_multiplier, 0);

        // Bounce rejection: 3 high / 2 low for 30 cycles
        p0 = pulse_cnt;
        for (int r = 0; r < 6; r++) begin
            btn_up = 1'b1; cycles(3);
            btn_up = 1'b0; cycles(2);
        end
        cycles(20);
        check("bounce_level", duty_multiplier, 0);
        check("bounce_pulses", pulse_cnt - p0, 0);

        // Saturation upward
        p0 = pulse_cnt;
        for (int r = 0; r < 10; r++) press_up();
        check("sat_up_level10", duty_multiplier, 10);
        check("sat_up_at_max", at_max, 1);
        press_up();
        press_up();
        check("sat_up_hold", duty_multiplier, 10);
        check("sat_up_pulses", pulse_cnt - p0, 10);

        // Saturation downward
        p0 = pulse_cnt;
        for (int r = 0; r < 12; r++) press_down();
        check("sat_dn_level", duty_multiplier, 0);
        check("sat_dn_at_min", at_min, 1);
        check("sat_dn_pulses", pulse_cnt - p0, 10);

        // Simultaneous press from level 5
        for (int r = 0; r < 5; r++) press_up();
        check("sim_start", duty_multiplier, 5);
        p0 = pulse_cnt;
        btn_up = 1'b1; btn_down = 1'b1;
        cycles(20);
        btn_up = 1'b0; btn_down = 1'b0;
        cycles(20);
        check("sim_level", duty_multiplier, 5);
        check("sim_pulses", pulse_cnt - p0, 0);

        // Reset mid-debounce from level 3, button held through reset
        press_down();
        press_down();
        check("mid_start", duty_multiplier, 3);
        btn_up = 1'b1;
        cycles(2);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        check("mid_after_reset", duty_multiplier, 0);
        p0 = pulse_cnt;
        cycles(20);
        btn_up = 1'b0;
        cycles(20);
        check("mid_one_step", duty_multiplier, 1);
        check("mid_pulses", pulse_cnt - p0, 1);

        // Randomized segments checked by the model every cycle
        for (int seg = 0; seg < 60; seg++) begin
            btn_up   = 1'($urandom_range(0, 1));
            btn_down = 1'($urandom_range(0, 1));
            cycles($urandom_range(1, 14));
        end
        btn_up = 1'b0; btn_down = 1'b0;
        cycles(20);
        if ($urandom_range(0, 3) == 0) begin
            rst = 1'b1; cycles(2); rst = 1'b0;
        end
        for (int seg = 0; seg < 40; seg++) begin
            btn_up   = 1'($urandom_range(0, 1));
            btn_down = (seg % 3 == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            cycles($urandom_range(4, 20));
        end
        btn_up = 1'b0; btn_down = 1'b0;
        cycles(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
